// File: rtl/vector_issue_sequencer.sv
// Replays one captured vector instruction to the decoder once per element,
// pacing each element by functional-unit class (single-cycle, multi-cycle, memory).
module vector_issue_sequencer #(
  parameter int VLEN   = 8,
  parameter int MC_LAT = 3,
  parameter int IDXW   = $clog2(VLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic            instr_in_valid,
  output logic            instr_in_ready,
  output logic [31:0]     instr_out,
  output logic            instr_out_valid,
  output logic [IDXW-1:0] element_idx,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            busy,
  output logic            done,
  output logic            illegal_op
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_MC, S_WAIT_MEM, S_DONE} state_t;
  typedef enum logic [1:0] {C_ILL, C_SC, C_MC, C_MEM} cls_t;

  function automatic cls_t decode(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001: decode = C_MEM;
      5'b00010, 5'b00011, 5'b00110, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
      5'b01101, 5'b01110, 5'b01111, 5'b10001, 5'b10010, 5'b10100, 5'b10111,
      5'b11000: decode = C_SC;
      5'b00100, 5'b00101, 5'b00111, 5'b01000, 5'b10000: decode = C_MC;
      default: decode = C_ILL;
    endcase
  endfunction

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d;
  logic [31:0]       instr_q, instr_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_pend_q, ack_pend_d;
  logic              out_valid_q, out_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              adv, last;
  cls_t              in_cls;

  assign last   = (idx_q == IDXW'(VLEN - 1));
  assign in_cls = decode(instr_in[31:27]);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    instr_d    = instr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ack_pend_d = ack_pend_q;
    illegal_d  = 1'b0;
    adv        = 1'b0;
    case (state_q)
      S_IDLE: if (instr_in_valid) begin
        // Illegal opcodes are consumed without disturbing the decoder-facing copy.
        if (in_cls == C_ILL) illegal_d = 1'b1;
        else begin
          instr_d = instr_in;
          cls_d   = in_cls;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: case (cls_q)
        C_SC:  adv = 1'b1;
        C_MC:  begin cnt_d = 4'(MC_LAT - 1); state_d = S_WAIT_MC; end
        C_MEM: begin ack_pend_d = mem_ack; state_d = S_WAIT_MEM; end
        default: state_d = S_IDLE;
      endcase
      S_WAIT_MC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) adv = 1'b1;
      end
      // An ack seen during ISSUE is remembered so every element still costs >= 2 cycles.
      S_WAIT_MEM: if (mem_ack || ack_pend_q) begin
        ack_pend_d = 1'b0;
        adv        = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (last) state_d = S_DONE;
      else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_ISSUE;
      end
    end
    out_valid_d = (state_d == S_ISSUE);
    mem_req_d   = (state_d == S_ISSUE && cls_d == C_MEM) ||
                  (state_d == S_WAIT_MEM && !ack_pend_d);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cls_q       <= C_ILL;
      instr_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ack_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      instr_q     <= instr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ack_pend_q  <= ack_pend_d;
      out_valid_q <= out_valid_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_in_ready  = (state_q == S_IDLE) && !reset;
  assign instr_out       = instr_q;
  assign instr_out_valid = out_valid_q;
  assign element_idx     = idx_q;
  assign mem_req         = mem_req_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign illegal_op      = illegal_q;

endmodule
